// File: rtl/mem_rr_arbiter_pkg.sv
// Shared definitions for the round-robin memory arbiter and the core-side bus glue.
// Holds the sequencer state encoding and the flattened request-bus field layout.
package mem_rr_arbiter_pkg;

    localparam int unsigned CTRL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_e;

    // LSB of requester idx's field in a flattened per-requester bus of fields width bits wide.
    function automatic int unsigned fld_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after the pointer.
// Eligibility is the request vector masked by the lock mask.
module mem_rr_arbiter_rr_pick #(
    parameter int unsigned NREQ = 2
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    input  logic [NREQ-1:0]         mask_i,
    output logic [NREQ-1:0]         gnt_oh_c_o,
    output logic [$clog2(NREQ)-1:0] gnt_idx_c_o,
    output logic                    gnt_vld_c_o
);

    localparam int unsigned IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]  elig;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk NREQ slots from the pointer; the wrap is a single subtract since ptr and k are both < NREQ.
    always_comb begin
        elig        = req_i & mask_i;
        found       = 1'b0;
        sum         = '0;
        cand        = '0;
        gnt_idx_c_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NREQ)) begin
                sum = sum - (IDX_W+1)'(NREQ);
            end
            cand = sum[IDX_W-1:0];
            if (!found && elig[cand]) begin
                found       = 1'b1;
                gnt_idx_c_o = cand;
            end
        end
        gnt_vld_c_o = found;
        gnt_oh_c_o  = found ? (NREQ'(1) << gnt_idx_c_o) : '0;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between NREQ requesters,
// with start timeout and bus lock for atomic read-modify-write sequences.
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned START_TO = 16
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic                     init_done,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*CTRL_W-1:0]   req_ctrl,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     rsp_err,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [$clog2(NREQ)-1:0]  grant,
    output logic                     mem_le,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [CTRL_W-1:0]        mem_ctrl,
    input  logic                     mem_busy,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned TO_W  = $clog2(START_TO + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0] lock_own_q, lock_own_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic             le_q, le_d;
    logic             we_q, we_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]  req_ack_c;

    logic [ADDR_W-1:0] addr_a  [NREQ];
    logic [DATA_W-1:0] wdata_a [NREQ];
    logic [CTRL_W-1:0] ctrl_a  [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[fld_lsb(g, ADDR_W) +: ADDR_W];
        assign wdata_a[g] = req_wdata[fld_lsb(g, DATA_W) +: DATA_W];
        assign ctrl_a[g]  = req_ctrl[fld_lsb(g, CTRL_W) +: CTRL_W];
    end

    logic [NREQ-1:0]  lock_mask;
    logic [NREQ-1:0]  pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    // While a lock is held only its owner may win arbitration.
    assign lock_mask = lock_vld_q ? (NREQ'(1) << lock_own_q) : {NREQ{1'b1}};

    mem_rr_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .mask_i      (lock_mask),
        .gnt_oh_c_o  (pick_oh),
        .gnt_idx_c_o (pick_idx),
        .gnt_vld_c_o (pick_vld)
    );

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            lock_vld_q  <= 1'b0;
            lock_own_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ctrl_q      <= '0;
            le_q        <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_own_q  <= lock_own_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ctrl_q      <= ctrl_d;
            le_q        <= le_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Strobes and rsp_valid are set on the transition into their state so they leave flops.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        lock_vld_d  = lock_vld_q;
        lock_own_d  = lock_own_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ctrl_d      = ctrl_q;
        le_d        = le_q;
        we_d        = we_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        req_ack_c   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (init_done && !mem_busy && pick_vld) begin
                    req_ack_c = pick_oh;
                    grant_d   = pick_idx;
                    addr_d    = addr_a[pick_idx];
                    wdata_d   = wdata_a[pick_idx];
                    ctrl_d    = ctrl_a[pick_idx];
                    le_d      = !req_we[pick_idx];
                    we_d      = req_we[pick_idx];
                    cnt_d     = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_busy) begin
                    le_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TO_W'(START_TO - 1)) begin
                    le_d        = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = NREQ'(1) << grant_q;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!mem_busy) begin
                    rdata_d     = mem_rdata;
                    rsp_valid_d = NREQ'(1) << grant_q;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (req_lock[grant_q]) begin
                    lock_vld_d = 1'b1;
                    lock_own_d = grant_q;
                end else begin
                    lock_vld_d = 1'b0;
                    ptr_d      = (grant_q == IDX_W'(NREQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ack   = req_ack_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign grant     = grant_q;
    assign mem_le    = le_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_ctrl  = ctrl_q;

endmodule
